// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: shared definitions for the EX-stage multiply/divide unit.
//   HILO_WD      width of the HI/LO write bus {hiwen, lowen, hidata, lodata}
//   DIV_CYCLES   radix-2 divide iterations (32-bit operands)
//   MUL_CYCLES   shift-add multiply iterations (iterative build only)
//   EX_STALL_BIT index of the EX stage in the 6-bit stall vector
//   md_state_e   unit state encoding (MD_IDLE, MD_DIV, MD_MUL, MD_DONE)
//   abs32()      magnitude of a 32-bit operand, signed or unsigned view
package ex_muldiv_pkg;

  localparam int HILO_WD      = 66;
  localparam int DIV_CYCLES   = 32;
  localparam int MUL_CYCLES   = 32;
  localparam int EX_STALL_BIT = 3;
  localparam int CNT_W        = 6;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_DIV  = 2'd1,
    MD_MUL  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  // Magnitude for the signed view; the unsigned view passes the raw value.
  // The most negative value maps to itself, which is correct as an
  // unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: ID/EX <-> multiply/divide unit signal bundle.
//   master : the pipeline side (drives stall, decode flags, operands;
//            receives stall request, busy, HI/LO write bus, state debug)
//   slave  : the ex_muldiv unit
// Handshake: an operation is issued by holding exactly one decode flag in a
// cycle where the unit is idle. While stallreq_for_ex=1 the pipeline holds
// EX; the HI/LO write is valid in any cycle where hiwen or lowen is set and
// is idempotent, so a write repeated while EX is held is harmless.
import ex_muldiv_pkg::*;

interface ex_muldiv_if;
  logic [5:0]         stall;
  logic               inst_div;
  logic               inst_divu;
  logic               inst_mult;
  logic               inst_multu;
  logic               inst_mthi;
  logic               inst_mtlo;
  logic [31:0]        src1;
  logic [31:0]        src2;
  logic               stallreq_for_ex;
  logic               busy;
  logic [HILO_WD-1:0] ex_hilo;
  md_state_e          state_dbg;

  modport master (
    output stall, inst_div, inst_divu, inst_mult, inst_multu, inst_mthi, inst_mtlo,
           src1, src2,
    input  stallreq_for_ex, busy, ex_hilo, state_dbg
  );

  modport slave (
    input  stall, inst_div, inst_divu, inst_mult, inst_multu, inst_mthi, inst_mtlo,
           src1, src2,
    output stallreq_for_ex, busy, ex_hilo, state_dbg
  );
endinterface

// File: rtl/ex_muldiv_div_iter.sv
// ex_muldiv_div_iter: restoring radix-2 divider datapath (unsigned).
//   clk, rst  clock, synchronous active-high reset
//   load      capture dividend/divisor and clear the partial remainder
//   step      perform one shift/subtract iteration
//   dividend  unsigned dividend (magnitude)
//   divisor   unsigned divisor (magnitude, nonzero)
//   quo_next  quotient after the current step (combinational)
//   rem_next  remainder after the current step (combinational)
// The quotient register initially holds the dividend; each step shifts one
// dividend bit into the remainder and one quotient bit in at the bottom.
import ex_muldiv_pkg::*;

module ex_muldiv_div_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quo_next,
  output logic [31:0] rem_next
);

  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dsr_q, dsr_d;

  logic [32:0] rem_shift;
  logic [32:0] trial;
  logic        take;

  // rem_shift < 2*divisor, so whichever branch is kept fits in 32 bits.
  always_comb begin
    rem_shift = {rem_q, quo_q[31]};
    trial     = rem_shift - {1'b0, dsr_q};
    take      = ~trial[32];
    rem_next  = take ? trial[31:0] : rem_shift[31:0];
    quo_next  = {quo_q[30:0], take};
  end

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dsr_d = dsr_q;
    if (load) begin
      rem_d = '0;
      quo_d = dividend;
      dsr_d = divisor;
    end else if (step) begin
      rem_d = rem_next;
      quo_d = quo_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dsr_q <= dsr_d;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: EX-stage multiply / divide / mthi / mtlo unit.
//   clk  clock
//   rst  synchronous, active-high reset (outputs forced to 0 while high)
//   bus  ex_muldiv_if.slave:
//        stall[5:0]       pipeline stall vector, stall[3] holds EX
//        inst_div/divu/mult/multu/mthi/mtlo  one-hot decode flags
//        src1, src2       forwarded rs / rt values
//        stallreq_for_ex  stall request while an operation is in flight
//        busy             state is not MD_IDLE
//        ex_hilo          {hiwen, lowen, hidata, lodata}
//        state_dbg        current FSM state
// Build option: define MULDIV_FAST_MUL_EN for a single-cycle combinational
// 32x32 multiply; otherwise multiplies run 32 shift-add iterations.
// Divide by zero completes in one cycle with LO=all ones and HI=dividend.
import ex_muldiv_pkg::*;

module ex_muldiv (
  input  logic        clk,
  input  logic        rst,
  ex_muldiv_if.slave  bus
);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic             q_neg_q, q_neg_d;   // negate quotient / product
  logic             r_neg_q, r_neg_d;   // negate remainder

  logic        is_div, is_mul, op_signed, div_zero;
  logic [31:0] a_abs, b_abs;
  logic        div_load, div_step;
  logic [31:0] div_quo_next, div_rem_next;
  logic        unused_stall;

  assign is_div    = bus.inst_div | bus.inst_divu;
  assign is_mul    = bus.inst_mult | bus.inst_multu;
  assign op_signed = bus.inst_div | bus.inst_mult;
  assign div_zero  = (bus.src2 == 32'd0);
  assign a_abs     = abs32(bus.src1, op_signed);
  assign b_abs     = abs32(bus.src2, op_signed);

  // Only the EX hold bit matters to this unit.
  assign unused_stall = ^{bus.stall[5:EX_STALL_BIT+1], bus.stall[EX_STALL_BIT-1:0]};

  assign div_load = (state_q == MD_IDLE) && is_div && !div_zero;
  assign div_step = (state_q == MD_DIV);

  ex_muldiv_div_iter u_div_iter (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .step     (div_step),
    .dividend (a_abs),
    .divisor  (b_abs),
    .quo_next (div_quo_next),
    .rem_next (div_rem_next)
  );

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] ext_a, ext_b, fast_prod;
  // Sign-extend for mult; the low 64 bits of the 64x64 product are the
  // exact two's-complement 32x32 product.
  always_comb begin
    ext_a     = {{32{op_signed & bus.src1[31]}}, bus.src1};
    ext_b     = {{32{op_signed & bus.src2[31]}}, bus.src2};
    fast_prod = ext_a * ext_b;
  end
`else
  logic [31:0] mcand_q, mcand_d;
  logic [63:0] prod_q, prod_d, prod_step;
  logic [32:0] mul_sum;
  // prod_q low half starts as the multiplier; each step conditionally adds
  // the multiplicand to the high half and shifts the whole thing right.
  always_comb begin
    mul_sum   = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);
    prod_step = {mul_sum, prod_q[31:1]};
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= MD_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: begin
        if (is_div) begin
          state_d = div_zero ? MD_DONE : MD_DIV;
        end
`ifndef MULDIV_FAST_MUL_EN
        else if (is_mul) begin
          state_d = MD_MUL;
        end
`endif
      end
      MD_DIV:  if (cnt_q == DIV_LAST) state_d = MD_DONE;
      MD_MUL:  if (cnt_q == MUL_LAST) state_d = MD_DONE;
      MD_DONE: if (!bus.stall[EX_STALL_BIT]) state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  // Datapath next values; sign fix-up lands in hi/lo on entry to MD_DONE.
  always_comb begin
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
`ifndef MULDIV_FAST_MUL_EN
    mcand_d = mcand_q;
    prod_d  = prod_q;
`endif
    case (state_q)
      MD_IDLE: begin
        cnt_d = '0;
        if (is_div) begin
          q_neg_d = op_signed & (bus.src1[31] ^ bus.src2[31]);
          r_neg_d = op_signed & bus.src1[31];
          if (div_zero) begin
            hi_d = bus.src1;
            lo_d = 32'hFFFF_FFFF;
          end
        end
`ifndef MULDIV_FAST_MUL_EN
        else if (is_mul) begin
          q_neg_d = op_signed & (bus.src1[31] ^ bus.src2[31]);
          mcand_d = a_abs;
          prod_d  = {32'd0, b_abs};
        end
`endif
      end
      MD_DIV: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == DIV_LAST) begin
          lo_d = q_neg_q ? (32'd0 - div_quo_next) : div_quo_next;
          hi_d = r_neg_q ? (32'd0 - div_rem_next) : div_rem_next;
        end
      end
      MD_MUL: begin
`ifndef MULDIV_FAST_MUL_EN
        cnt_d  = cnt_q + CNT_W'(1);
        prod_d = prod_step;
        if (cnt_q == MUL_LAST) begin
          {hi_d, lo_d} = q_neg_q ? (64'd0 - prod_step) : prod_step;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
`ifndef MULDIV_FAST_MUL_EN
      mcand_q <= '0;
      prod_q  <= '0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
`ifndef MULDIV_FAST_MUL_EN
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
`endif
    end
  end

  // Output logic
  always_comb begin
    bus.stallreq_for_ex = 1'b0;
    bus.ex_hilo         = '0;
    if (!rst) begin
      case (state_q)
        MD_IDLE: begin
          if (is_div) begin
            bus.stallreq_for_ex = 1'b1;
          end else if (is_mul) begin
`ifdef MULDIV_FAST_MUL_EN
            bus.ex_hilo = {2'b11, fast_prod};
`else
            bus.stallreq_for_ex = 1'b1;
`endif
          end else if (bus.inst_mthi) begin
            bus.ex_hilo = {2'b10, bus.src1, 32'd0};
          end else if (bus.inst_mtlo) begin
            bus.ex_hilo = {2'b01, 32'd0, bus.src1};
          end
        end
        MD_DIV, MD_MUL: bus.stallreq_for_ex = 1'b1;
        MD_DONE:        bus.ex_hilo = {2'b11, hi_q, lo_q};
        default: ;
      endcase
    end
  end

  assign bus.busy      = !rst && (state_q != MD_IDLE);
  assign bus.state_dbg = state_q;

  // ID decode guarantees at most one flag per instruction.
  a_flags_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0({bus.inst_div, bus.inst_divu, bus.inst_mult, bus.inst_multu,
              bus.inst_mthi, bus.inst_mtlo}));

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed scoreboard bench for ex_muldiv.
// Honors MULDIV_FAST_MUL_EN for the expected multiply stall length.
import ex_muldiv_pkg::*;

module tb_ex_muldiv;

  localparam int OP_DIV = 0, OP_DIVU = 1, OP_MULT = 2, OP_MULTU = 3, OP_MTHI = 4, OP_MTLO = 5;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_STALL = 0;
`else
  localparam int MUL_STALL = 33;
`endif

  logic clk;
  logic rst;
  ex_muldiv_if bus();

  ex_muldiv dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [HILO_WD-1:0] exp_q[$];
  logic in_wr = 1'b0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [HILO_WD-1:0] act, input logic [HILO_WD-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_flags();
    bus.inst_div   = 1'b0;
    bus.inst_divu  = 1'b0;
    bus.inst_mult  = 1'b0;
    bus.inst_multu = 1'b0;
    bus.inst_mthi  = 1'b0;
    bus.inst_mtlo  = 1'b0;
  endtask

  task automatic set_flag(input int op);
    clear_flags();
    case (op)
      OP_DIV:   bus.inst_div   = 1'b1;
      OP_DIVU:  bus.inst_divu  = 1'b1;
      OP_MULT:  bus.inst_mult  = 1'b1;
      OP_MULTU: bus.inst_multu = 1'b1;
      OP_MTHI:  bus.inst_mthi  = 1'b1;
      default:  bus.inst_mtlo  = 1'b1;
    endcase
  endtask

  // ---------------- driver ----------------
  // Issues one instruction, counts stall-request cycles, optionally holds
  // EX in the completion cycle, then checks the unit is back to idle.
  task automatic run_op(input string nm, input int op, input logic [31:0] a, input logic [31:0] b,
                        input logic [HILO_WD-1:0] exp, input int exp_stall, input int hold);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    @(posedge clk);
    #1;
    exp_q.push_back(exp);
    bus.src1 = a;
    bus.src2 = b;
    set_flag(op);
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (bus.stallreq_for_ex) begin
        n++;
        // Operands are latched in the start cycle; later changes must not matter.
        if (n > 1) begin
          #1;
          bus.src1 = $urandom;
          bus.src2 = $urandom;
        end
      end else begin
        done = 1'b1;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: stall request still high after 100 cycles", nm);
    end
    chk({nm, "_stall_cycles"}, HILO_WD'(n), HILO_WD'(exp_stall));
    #1;
    if (hold > 0) begin
      bus.stall[EX_STALL_BIT] = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        chk({nm, "_hold_busy"}, HILO_WD'(bus.busy), HILO_WD'(1));
      end
      #1;
      bus.stall[EX_STALL_BIT] = 1'b0;
    end
    clear_flags();
    @(negedge clk);
    chk({nm, "_idle_busy"}, HILO_WD'(bus.busy), '0);
    chk({nm, "_idle_stallreq"}, HILO_WD'(bus.stallreq_for_ex), '0);
    chk({nm, "_idle_hilo"}, bus.ex_hilo, '0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  // Compares every HI/LO write cycle against the head of the queue; the
  // entry retires when the write ends (DONE may repeat it while EX is held).
  always @(negedge clk) begin
    if (bus.ex_hilo[65] || bus.ex_hilo[64]) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got %h expected no write", bus.ex_hilo);
      end else begin
        chk("hilo_write", bus.ex_hilo, exp_q[0]);
      end
      in_wr = 1'b1;
    end else if (in_wr) begin
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      in_wr = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b1;
    bus.stall = 6'd0;
    clear_flags();
    bus.src1  = 32'h0000_CAFE;
    bus.src2  = 32'd0;
    bus.inst_mthi = 1'b1;     // must be ignored while in reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_hilo", bus.ex_hilo, '0);
    chk("reset_busy", HILO_WD'(bus.busy), '0);
    chk("reset_stallreq", HILO_WD'(bus.stallreq_for_ex), '0);
    #1;
    clear_flags();
    rst = 1'b0;
    @(negedge clk);
    chk("idle_noflag_hilo", bus.ex_hilo, '0);

    run_op("divu_100_7",   OP_DIVU, 32'd100,      32'd7,        {2'b11, 32'd2,         32'd14},        33, 0);
    run_op("div_m7_2",     OP_DIV,  32'hFFFFFFF9, 32'd2,        {2'b11, 32'hFFFFFFFF,  32'hFFFFFFFD},  33, 0);
    run_op("div_7_m2",     OP_DIV,  32'd7,        32'hFFFFFFFE, {2'b11, 32'h00000001,  32'hFFFFFFFD},  33, 0);
    run_op("div_m100_m7",  OP_DIV,  32'hFFFFFF9C, 32'hFFFFFFF9, {2'b11, 32'hFFFFFFFE,  32'h0000000E},  33, 0);
    run_op("divu_max_1",   OP_DIVU, 32'hFFFFFFFF, 32'd1,        {2'b11, 32'h00000000,  32'hFFFFFFFF},  33, 0);
    run_op("divu_by_zero", OP_DIVU, 32'h00001234, 32'd0,        {2'b11, 32'h00001234,  32'hFFFFFFFF},  1,  0);
    run_op("div_by_zero",  OP_DIV,  32'hFFFFFFFB, 32'd0,        {2'b11, 32'hFFFFFFFB,  32'hFFFFFFFF},  1,  0);
    run_op("divu_hold",    OP_DIVU, 32'd1000,     32'd10,       {2'b11, 32'h00000000,  32'h00000064},  33, 3);

    run_op("mult_m1_2",    OP_MULT,  32'hFFFFFFFF, 32'd2,        {2'b11, 32'hFFFFFFFF, 32'hFFFFFFFE}, MUL_STALL, 0);
    run_op("multu_max_2",  OP_MULTU, 32'hFFFFFFFF, 32'd2,        {2'b11, 32'h00000001, 32'hFFFFFFFE}, MUL_STALL, 0);
    run_op("mult_m3_m5",   OP_MULT,  32'hFFFFFFFD, 32'hFFFFFFFB, {2'b11, 32'h00000000, 32'h0000000F}, MUL_STALL, 0);
    run_op("mult_min_min", OP_MULT,  32'h80000000, 32'h80000000, {2'b11, 32'h40000000, 32'h00000000}, MUL_STALL, 0);
    run_op("multu_max_max",OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, {2'b11, 32'hFFFFFFFE, 32'h00000001}, MUL_STALL, 0);
    run_op("mult_7_m3",    OP_MULT,  32'd7,        32'hFFFFFFFD, {2'b11, 32'hFFFFFFFF, 32'hFFFFFFEB}, MUL_STALL, 0);

    run_op("mthi_cafe",    OP_MTHI,  32'h0000CAFE, 32'd5,        {2'b10, 32'h0000CAFE, 32'h00000000}, 0, 0);
    run_op("mtlo_beef",    OP_MTLO,  32'h0000BEEF, 32'd9,        {2'b01, 32'h00000000, 32'h0000BEEF}, 0, 0);

    // Reset in the middle of a divide: no write may follow.
    @(posedge clk);
    #1;
    bus.src1 = 32'd1000;
    bus.src2 = 32'd3;
    set_flag(OP_DIV);
    repeat (11) @(negedge clk);   // start cycle + 10 iterations
    chk("abort_pre_busy", HILO_WD'(bus.busy), HILO_WD'(1));
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rst_busy", HILO_WD'(bus.busy), '0);
    chk("abort_rst_stallreq", HILO_WD'(bus.stallreq_for_ex), '0);
    chk("abort_rst_hilo", bus.ex_hilo, '0);
    #1;
    rst = 1'b0;
    clear_flags();
    @(negedge clk);
    chk("abort_after_busy", HILO_WD'(bus.busy), '0);
    chk("abort_after_stallreq", HILO_WD'(bus.stallreq_for_ex), '0);
    chk("abort_after_hilo", bus.ex_hilo, '0);
    repeat (40) @(negedge clk);   // monitor flags any late write
    chk("abort_state_idle", HILO_WD'(bus.state_dbg), HILO_WD'(MD_IDLE));

    chk("scoreboard_empty", HILO_WD'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
